// File: rtl/sample_ring_buffer_if.sv
// rtl/sample_ring_buffer_if.sv - age-indexed read request/response port of the sample ring buffer
interface sample_ring_buffer_if #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 128
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              read_req;
  logic [ADDR_W-1:0] read_age;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;
  logic              read_err;

  // Computation unit side: issues requests, receives responses.
  modport master (
    output read_req, read_age,
    input  read_data, read_valid, read_err
  );

  // Buffer side: serves requests.
  modport slave (
    input  read_req, read_age,
    output read_data, read_valid, read_err
  );
endinterface

// File: rtl/sample_ring_buffer.sv
// rtl/sample_ring_buffer.sv - circular ADC sample buffer with age-indexed reads and freeze
module sample_ring_buffer #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 128,
  parameter int DROP_W = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clear,
  input  logic              freeze,
  sample_ring_buffer_if.slave rd,
  output logic [DATA_W-1:0] latest_output,
  output logic [ADDR_W-1:0] index,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              wrap,
  output logic [DROP_W-1:0] dropped
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              write_en_q;
  logic              wr_event;
  logic              wr_accept;
  logic [ADDR_W-1:0] rd_addr;
  logic              age_ok;

  // One event per rising edge of the strobe, however long it stays high.
  assign wr_event  = write_en & ~write_en_q;
  // Clear wins over a same-cycle event; freeze diverts it to the drop counter.
  assign wr_accept = wr_event & ~freeze & ~clear;
  // Age 0 is the slot just behind the write pointer; wraps naturally in ADDR_W bits.
  assign rd_addr   = index - ADDR_W'(1) - rd.read_age;
  // Ages at or beyond the fill level would expose stale memory.
  assign age_ok    = {1'b0, rd.read_age} < count;
  assign full      = (count == FULL_COUNT);

  // Sample storage; left unreset so it can map onto a RAM.
  always_ff @(posedge clk) begin
    if (reset && wr_accept) begin
      mem[index] <= data_in;
    end
  end

  // Write-side pointer, fill level, wrap pulse and drop accounting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      write_en_q    <= 1'b0;
      latest_output <= '0;
      index         <= '0;
      count         <= '0;
      wrap          <= 1'b0;
      dropped       <= '0;
    end else begin
      write_en_q <= write_en;
      wrap       <= 1'b0;
      if (clear) begin
        index   <= '0;
        count   <= '0;
        dropped <= '0;
      end else if (wr_event) begin
        if (freeze) begin
          if (dropped != '1) begin
            dropped <= dropped + DROP_W'(1);
          end
        end else begin
          latest_output <= data_in;
          index         <= index + ADDR_W'(1);
          wrap          <= &index;
          if (count != FULL_COUNT) begin
            count <= count + (ADDR_W+1)'(1);
          end
        end
      end
    end
  end

  // Registered read response, one cycle after the request, using pre-edge pointers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd.read_data  <= '0;
      rd.read_valid <= 1'b0;
      rd.read_err   <= 1'b0;
    end else if (clear) begin
      rd.read_valid <= 1'b0;
      rd.read_err   <= 1'b0;
    end else begin
      rd.read_valid <= rd.read_req;
      if (rd.read_req) begin
        if (age_ok) begin
          rd.read_data <= mem[rd_addr];
          rd.read_err  <= 1'b0;
        end else begin
          rd.read_data <= '0;
          rd.read_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sample_ring_buffer.sv
// tb/tb_sample_ring_buffer.sv - scoreboard bench for sample_ring_buffer
module tb_sample_ring_buffer;
  localparam int DATA_W = 12;
  localparam int DEPTH  = 128;
  localparam int DROP_W = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] data;
  } resp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              write_en;
  logic [DATA_W-1:0] data_in;
  logic              clear;
  logic              freeze;
  logic [DATA_W-1:0] latest_output;
  logic [ADDR_W-1:0] index;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              wrap;
  logic [DROP_W-1:0] dropped;

  int errors = 0;
  int checks = 0;
  int wrap_cnt;
  int wrap_val;
  resp_t exp_q[$];
  resp_t got_exp;

  sample_ring_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) rd_if ();

  sample_ring_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk(clk),
    .reset(reset),
    .write_en(write_en),
    .data_in(data_in),
    .clear(clear),
    .freeze(freeze),
    .rd(rd_if),
    .latest_output(latest_output),
    .index(index),
    .count(count),
    .full(full),
    .wrap(wrap),
    .dropped(dropped)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected the bench to finish");
    $fatal(1, "watchdog");
  end

  // Monitor: every response the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin
    if (rd_if.read_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read_valid: got read_valid=1 data=%h err=%0b, expected no response",
                 rd_if.read_data, rd_if.read_err);
      end else begin
        got_exp = exp_q.pop_front();
        if (rd_if.read_err !== got_exp.err || rd_if.read_data !== got_exp.data) begin
          errors++;
          $display("FAIL read_resp: got err=%0b data=%h, expected err=%0b data=%h",
                   rd_if.read_err, rd_if.read_data, got_exp.err, got_exp.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [DATA_W-1:0] d);
    write_en = 1'b1;
    data_in  = d;
    tick();
    if (wrap === 1'b1) begin
      wrap_cnt++;
      wrap_val = int'(d);
    end
    write_en = 1'b0;
    tick();
    if (wrap === 1'b1) wrap_cnt++;
  endtask

  task automatic read(input logic [ADDR_W-1:0] age, input logic err, input logic [DATA_W-1:0] d);
    rd_if.read_req = 1'b1;
    rd_if.read_age = age;
    exp_q.push_back('{err: err, data: d});
    tick();
    rd_if.read_req = 1'b0;
    tick();
    check("read_latency_pending", exp_q.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_latest"},  latest_output, 0);
    check({tag, "_index"},   index, 0);
    check({tag, "_count"},   count, 0);
    check({tag, "_full"},    full, 0);
    check({tag, "_wrap"},    wrap, 0);
    check({tag, "_dropped"}, dropped, 0);
    check({tag, "_rvalid"},  rd_if.read_valid, 0);
    check({tag, "_rerr"},    rd_if.read_err, 0);
    check({tag, "_rdata"},   rd_if.read_data, 0);
  endtask

  initial begin
    reset = 1'b0; write_en = 1'b0; data_in = '0; clear = 1'b0; freeze = 1'b0;
    rd_if.read_req = 1'b0; rd_if.read_age = '0;
    tick();
    tick();
    check_reset_state("rst");
    reset = 1'b1;
    tick();

    // Five single-cycle strobes carrying 1..5.
    for (int i = 1; i <= 5; i++) strobe(DATA_W'(i));
    check("t1_latest", latest_output, 5);
    check("t1_index", index, 5);
    check("t1_count", count, 5);
    read(0, 1'b0, 12'd5);
    read(4, 1'b0, 12'd1);
    read(5, 1'b1, 12'd0);

    // Strobe held high for four cycles produces one write.
    write_en = 1'b1;
    data_in  = 12'hABC;
    repeat (4) tick();
    write_en = 1'b0;
    tick();
    check("hold_count", count, 6);
    check("hold_index", index, 6);
    check("hold_latest", latest_output, 12'hABC);

    // Freeze drops samples and keeps contents readable.
    freeze = 1'b1;
    strobe(12'h111);
    strobe(12'h222);
    strobe(12'h333);
    check("frz_dropped", dropped, 3);
    check("frz_count", count, 6);
    check("frz_latest", latest_output, 12'hABC);
    read(0, 1'b0, 12'hABC);
    read(1, 1'b0, 12'd5);
    freeze = 1'b0;
    strobe(12'h007);
    check("unfrz_count", count, 7);
    check("unfrz_latest", latest_output, 12'h007);
    check("unfrz_dropped", dropped, 3);

    // Clear, then 130 writes to wrap the ring.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_count", count, 0);
    check("clr_index", index, 0);
    check("clr_dropped", dropped, 0);
    check("clr_latest", latest_output, 12'h007);
    wrap_cnt = 0;
    wrap_val = -1;
    for (int i = 0; i < 130; i++) strobe(DATA_W'(i));
    check("wrap_pulses", wrap_cnt, 1);
    check("wrap_value", wrap_val, 127);
    check("wrap_full", full, 1);
    check("wrap_count", count, 128);
    check("wrap_index", index, 2);
    read(0, 1'b0, 12'd129);
    read(127, 1'b0, 12'd2);

    // Same-edge write and read: age 0 returns the prior sample.
    write_en = 1'b1;
    data_in  = 12'h055;
    rd_if.read_req = 1'b1;
    rd_if.read_age = '0;
    exp_q.push_back('{err: 1'b0, data: 12'd129});
    tick();
    write_en = 1'b0;
    rd_if.read_req = 1'b0;
    tick();
    check("same_edge_pending", exp_q.size(), 0);
    read(0, 1'b0, 12'h055);

    // Clear together with a write event discards the sample.
    write_en = 1'b1;
    data_in  = 12'h066;
    clear    = 1'b1;
    tick();
    write_en = 1'b0;
    clear    = 1'b0;
    tick();
    check("clrw_count", count, 0);
    check("clrw_index", index, 0);
    check("clrw_dropped", dropped, 0);
    check("clrw_latest", latest_output, 12'h055);
    read(0, 1'b1, 12'd0);

    // Reset mid-stream with a write event and a read request in the reset cycle.
    for (int i = 0; i < 10; i++) strobe(DATA_W'(12'h200 + i));
    check("pre_rst_count", count, 10);
    reset    = 1'b0;
    write_en = 1'b1;
    data_in  = 12'h3FF;
    rd_if.read_req = 1'b1;
    tick();
    check_reset_state("mid_rst");
    reset    = 1'b1;
    write_en = 1'b0;
    rd_if.read_req = 1'b0;
    tick();
    check("post_rst_count", count, 0);
    strobe(12'h3C3);
    check("post_rst_w_count", count, 1);
    check("post_rst_w_index", index, 1);
    check("post_rst_w_latest", latest_output, 12'h3C3);
    read(0, 1'b0, 12'h3C3);
    read(1, 1'b1, 12'd0);

    tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
